count_seq_ctrl: RTL and testbench

- Sequencing controller directly upstream of the team's loadable up-counter; drives the counter's load/data_in and watches its count output.
- Per programmed period: loads a start value, waits for the counter to reach a terminal value, emits a tick, then reloads. Repeats for a programmed number of periods or runs continuously until aborted.

---
 rtl/count_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_count_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// Sequencer for a loadable up-counter: load a start value, wait for the terminal count, tick, repeat.
// Optional RUN-phase watchdog with an err output when COUNT_SEQ_CTRL_TIMEOUT_EN is defined.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; shadows hold the last accepted config
// S_LOAD | load_out high, counter takes data_out on the next edge
// S_RUN  | comparing cnt_in against the terminal shadow
// S_DONE | final period finished; done and tick high for one cycle
module count_seq_ctrl #(
    parameter int WIDTH = 5,
    parameter int INCR  = 1,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             load_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [REP_W-1:0] per_cnt
`ifdef COUNT_SEQ_CTRL_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // A zero step never moves the counter, so the terminal is treated as unreachable.
    localparam bit INCR_OK = (INCR > 0);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] term_q;
    logic [REP_W-1:0] reps_q;
    logic             tick_q, tick_nxt;
    logic             accept, per_inc, reps_dec;
    logic             match;

`ifdef COUNT_SEQ_CTRL_TIMEOUT_EN
    logic [WIDTH-1:0] run_tmr;
    logic             err_q, err_nxt;
    assign err = err_q;
`endif

    assign match    = INCR_OK && (state == S_RUN) && (cnt_in == term_q);
    assign load_out = (state == S_LOAD);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign tick     = tick_q;

    always_comb begin
        state_nxt = state;
        tick_nxt  = 1'b0;
        accept    = 1'b0;
        per_inc   = 1'b0;
        reps_dec  = 1'b0;
`ifdef COUNT_SEQ_CTRL_TIMEOUT_EN
        err_nxt   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (match) begin
                    tick_nxt = 1'b1;
                    per_inc  = 1'b1;
                    if (reps_q == REP_W'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_LOAD;
                        reps_dec  = (reps_q != '0);
                    end
                end
`ifdef COUNT_SEQ_CTRL_TIMEOUT_EN
                else if (run_tmr == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // data_out doubles as the start-value shadow: it only changes on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tick_q   <= 1'b0;
            data_out <= '0;
            term_q   <= '0;
            reps_q   <= '0;
            per_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            tick_q <= tick_nxt;
            if (accept) begin
                data_out <= cfg_start;
                term_q   <= cfg_term;
                reps_q   <= cfg_reps;
                per_cnt  <= '0;
            end
            if (per_inc) begin
                per_cnt <= per_cnt + REP_W'(1);
            end
            if (reps_dec) begin
                reps_q <= reps_q - REP_W'(1);
            end
        end
    end

`ifdef COUNT_SEQ_CTRL_TIMEOUT_EN
    // Down-counter reloaded in LOAD; reaching zero on the 2^WIDTH-th RUN cycle is the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_tmr <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_nxt;
            if (state == S_LOAD) begin
                run_tmr <= '1;
            end else if (state == S_RUN) begin
                run_tmr <= run_tmr - WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl driving a simple loadable up-counter.
// Timeout checks switch with COUNT_SEQ_CTRL_TIMEOUT_EN.
module tb_count_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] cfg_start;
    logic [4:0] cfg_term;
    logic [3:0] cfg_reps;
    logic [4:0] cnt_in;
    logic       load_out;
    logic [4:0] data_out;
    logic       busy;
    logic       tick;
    logic       done;
    logic [3:0] per_cnt;
`ifdef COUNT_SEQ_CTRL_TIMEOUT_EN
    logic       err;
`endif

    logic [4:0] step;
    int         total;
    int         bad;

    count_seq_ctrl #(.WIDTH(5), .INCR(1), .REP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_start (cfg_start),
        .cfg_term  (cfg_term),
        .cfg_reps  (cfg_reps),
        .cnt_in    (cnt_in),
        .load_out  (load_out),
        .data_out  (data_out),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .per_cnt   (per_cnt)
`ifdef COUNT_SEQ_CTRL_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream loadable up-counter
    always_ff @(posedge clk) begin
        if (rst)           cnt_in <= '0;
        else if (load_out) cnt_in <= data_out;
        else               cnt_in <= cnt_in + step;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One programmed run; p is the hand-computed period length.
    task automatic run_seq(input logic [4:0] s, input logic [4:0] t, input logic [3:0] r,
                           input int p, input bit poke);
        int last;
        int o;
        int pc;
        last = p * int'(r);
        cfg_start = s;
        cfg_term  = t;
        cfg_reps  = r;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= last + 2; c++) begin
            o  = (c - 1) % p;
            pc = (c - 1) / p;
            if (pc > int'(r)) pc = int'(r);
            chk($sformatf("load c%0d", c), int'(load_out), int'(o == 0 && c - 1 < last));
            chk($sformatf("tick c%0d", c), int'(tick), int'(o == 0 && c > 1 && c - 1 <= last));
            chk($sformatf("done c%0d", c), int'(done), int'(c - 1 == last));
            chk($sformatf("busy c%0d", c), int'(busy), int'(c - 1 <= last));
            chk($sformatf("per_cnt c%0d", c), int'(per_cnt), pc);
            if (o != 0 && c - 1 < last)
                chk($sformatf("cnt_in c%0d", c), int'(cnt_in), (int'(s) + (o - 1) * int'(step)) % 32);
            if (o == 0 && c - 1 < last)
                chk($sformatf("data_out c%0d", c), int'(data_out), int'(s));
            if (poke && c == 3) begin
                start = 1'b1; cfg_start = 5'd10; cfg_term = 5'd20; cfg_reps = 4'd5;
            end
            if (poke && c == 4) start = 1'b0;
            if (poke && c == last + 1) start = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; step = 5'd1;
        cfg_start = '0; cfg_term = '0; cfg_reps = '0;
        repeat (3) @(negedge clk);
        chk("rst load", int'(load_out), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst tick", int'(tick), 0);
        chk("rst done", int'(done), 0);
        chk("rst data", int'(data_out), 0);
        chk("rst per", int'(per_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        run_seq(5'd3, 5'd6, 4'd2, 5, 1'b0);
        run_seq(5'd30, 5'd1, 4'd2, 5, 1'b0);
        run_seq(5'd9, 5'd9, 4'd3, 2, 1'b0);

        // continuous run, then abort on a match cycle
        cfg_start = 5'd0; cfg_term = 5'd3; cfg_reps = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 85; c++) begin
            chk($sformatf("cont tick c%0d", c), int'(tick), int'((c - 1) % 5 == 0 && c > 1));
            chk($sformatf("cont load c%0d", c), int'(load_out), int'((c - 1) % 5 == 0));
            chk($sformatf("cont done c%0d", c), int'(done), 0);
            chk($sformatf("cont busy c%0d", c), int'(busy), 1);
            chk($sformatf("cont per c%0d", c), int'(per_cnt), ((c - 1) / 5) % 16);
            if (c == 85) begin
                chk("cont match cnt", int'(cnt_in), 3);
                abort = 1'b1;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        chk("abort tick", int'(tick), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort per", int'(per_cnt), 0);
        @(negedge clk);
        chk("abort idle busy", int'(busy), 0);

        // start together with abort in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("st+ab busy", int'(busy), 0);
        chk("st+ab load", int'(load_out), 0);
        @(negedge clk);
        chk("st+ab busy2", int'(busy), 0);

        // start while busy / cfg changes / start in DONE then next cycle
        run_seq(5'd3, 5'd6, 4'd2, 5, 1'b1);
        chk("restart load", int'(load_out), 1);
        chk("restart busy", int'(busy), 1);
        chk("restart data", int'(data_out), 10);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("restart abort busy", int'(busy), 0);
        @(negedge clk);

        // reset in the middle of RUN
        cfg_start = 5'd3; cfg_term = 5'd6; cfg_reps = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-rst busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-rst busy", int'(busy), 0);
        chk("mid-rst load", int'(load_out), 0);
        chk("mid-rst tick", int'(tick), 0);
        chk("mid-rst done", int'(done), 0);
        chk("mid-rst data", int'(data_out), 0);
        chk("mid-rst per", int'(per_cnt), 0);
        @(negedge clk);
        chk("post-rst busy", int'(busy), 0);
        run_seq(5'd3, 5'd6, 4'd2, 5, 1'b0);

        // unreachable terminal value: counter steps by 2 from 0, term 3
        step = 5'd2;
        cfg_start = 5'd0; cfg_term = 5'd3; cfg_reps = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef COUNT_SEQ_CTRL_TIMEOUT_EN
        for (int c = 1; c <= 40; c++) begin
            chk($sformatf("tmo err c%0d", c), int'(err), int'(c == 34));
            chk($sformatf("tmo busy c%0d", c), int'(busy), int'(c <= 33));
            chk($sformatf("tmo tick c%0d", c), int'(tick), 0);
            chk($sformatf("tmo done c%0d", c), int'(done), 0);
            @(negedge clk);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            chk($sformatf("hang tick c%0d", c), int'(tick), 0);
            chk($sformatf("hang busy c%0d", c), int'(busy), 1);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("hang abort busy", int'(busy), 0);
`endif
        step = 5'd1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
